// File: rtl/instr_encode_pkg.sv
// ============================================================================
// instr_encode_pkg : RV32I format selects, opcodes and NOP word for the encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package instr_encode_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;

endpackage

`default_nettype wire

// File: rtl/instr_pack.sv
// ============================================================================
// instr_pack : combinational RV32I field packer with immediate legality check
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_pack
  import instr_encode_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e w_fmt;
  logic w_i_ok;
  logic w_b_ok;
  logic w_j_ok;
  logic w_u_ok;

  assign w_fmt = fmt_e'(fmt);

  // An immediate fits when every bit above the field's sign bit matches it.
  assign w_i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign w_j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign w_u_ok = ~(|imm[11:0]);

  always_comb begin
    instr = NOP_INSTR;
    err   = 1'b1;
    case (w_fmt)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I: if (w_i_ok) begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_S: if (w_i_ok) begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = 1'b0;
      end
      FMT_B: if (w_b_ok) begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = 1'b0;
      end
      FMT_U: if (w_u_ok) begin
        instr = {imm[31:12], rd, opcode};
        err   = 1'b0;
      end
      FMT_J: if (w_j_ok) begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = 1'b0;
      end
      default: begin
        instr = NOP_INSTR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encode.sv
// ============================================================================
// instr_encode : two-stage valid/ready RV32I encoder with word address counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encode
  import instr_encode_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       word_cnt
);

  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(BASE_ADDR + 4 * (DEPTH - 1));

  logic              r_live;
  logic              r_s1_valid;
  logic [2:0]        r_s1_fmt;
  logic [6:0]        r_s1_opcode;
  logic [4:0]        r_s1_rd;
  logic [2:0]        r_s1_funct3;
  logic [4:0]        r_s1_rs1;
  logic [4:0]        r_s1_rs2;
  logic [6:0]        r_s1_funct7;
  logic [31:0]       r_s1_imm;
  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic              r_out_err;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_addr_ptr;
  logic [15:0]       r_word_cnt;

  logic              w_s2_load;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [31:0]       w_instr;
  logic              w_err;

  assign w_s2_load  = !r_out_valid || out_ready;
  assign in_ready   = r_live && (!r_s1_valid || w_s2_load) && !clear;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign out_addr  = r_out_addr;
  assign word_cnt  = r_word_cnt;

  instr_pack u_pack (
    .fmt    (r_s1_fmt),
    .opcode (r_s1_opcode),
    .rd     (r_s1_rd),
    .funct3 (r_s1_funct3),
    .rs1    (r_s1_rs1),
    .rs2    (r_s1_rs2),
    .funct7 (r_s1_funct7),
    .imm    (r_s1_imm),
    .instr  (w_instr),
    .err    (w_err)
  );

  // Raw field capture needs no reset: it is only observed behind r_s1_valid.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_fmt    <= in_fmt;
      r_s1_opcode <= in_opcode;
      r_s1_rd     <= in_rd;
      r_s1_funct3 <= in_funct3;
      r_s1_rs1    <= in_rs1;
      r_s1_rs2    <= in_rs2;
      r_s1_funct7 <= in_funct7;
      r_s1_imm    <= in_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live      <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0;
      r_out_err   <= 1'b0;
      r_out_addr  <= c_base;
      r_addr_ptr  <= c_base;
      r_word_cnt  <= 16'h0;
    end else begin
      r_live <= 1'b1;
      if (clear) begin
        r_s1_valid  <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_addr  <= c_base;
        r_addr_ptr  <= c_base;
        r_word_cnt  <= 16'h0;
      end else begin
        if (w_in_fire) begin
          r_s1_valid <= 1'b1;
        end else if (w_s2_load) begin
          r_s1_valid <= 1'b0;
        end
        // Address is bound when the word enters stage 2, so stalls never skip one.
        if (w_s2_load) begin
          r_out_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_out_instr <= w_instr;
            r_out_err   <= w_err;
            r_out_addr  <= r_addr_ptr;
            r_addr_ptr  <= (r_addr_ptr == c_last) ? c_base : r_addr_ptr + ADDR_W'(4);
          end
        end
        if (w_out_fire && (r_word_cnt != 16'hFFFF)) begin
          r_word_cnt <= r_word_cnt + 16'h1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encode.sv
// ============================================================================
// tb_instr_encode : vector table plus scoreboard bench for instr_encode
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_encode;
  import instr_encode_pkg::*;

  localparam int ADDR_W    = 12;
  localparam int BASE_ADDR = 'h40;
  localparam int DEPTH     = 4;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] ei;
    logic        ee;
  } vec_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic              err;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [15:0]       word_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   exp_idx = 0;
  logic [15:0] exp_cnt = 16'h0;
  logic mon_en = 1'b0;
  logic hold_valid = 1'b0;
  logic [31:0] hold_instr;
  logic [ADDR_W-1:0] hold_addr;
  logic hold_err;
  logic done;
  vec_t vecs [12];

  instr_encode #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_funct3 (in_funct3),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.fmt = f; v.op = op; v.rd = rd; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2;
    v.f7 = f7; v.imm = imm; v.ei = ei; v.ee = ee;
    return v;
  endfunction

  // Reference encoder: legality by signed range, packing bit-field by bit-field.
  function automatic logic [32:0] ref_enc(input vec_t v);
    logic [31:0] w;
    logic        ok;
    int          s;
    s = $signed(v.imm);
    w = 32'h0;
    w[6:0] = v.op;
    ok = 1'b1;
    case (v.fmt)
      3'd0: w[31:7] = {v.f7, v.rs2, v.rs1, v.f3, v.rd};
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w[31:20] = v.imm[11:0]; w[19:15] = v.rs1; w[14:12] = v.f3; w[11:7] = v.rd;
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w[31:25] = v.imm[11:5]; w[24:20] = v.rs2; w[19:15] = v.rs1;
        w[14:12] = v.f3; w[11:7] = v.imm[4:0];
      end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4095) && !v.imm[0];
        w[31] = v.imm[12]; w[30:25] = v.imm[10:5]; w[24:20] = v.rs2; w[19:15] = v.rs1;
        w[14:12] = v.f3; w[11:8] = v.imm[4:1]; w[7] = v.imm[11];
      end
      3'd4: begin
        ok = (v.imm[11:0] == 12'h0);
        w[31:12] = v.imm[31:12]; w[11:7] = v.rd;
      end
      3'd5: begin
        ok = (s >= -(1 << 20)) && (s < (1 << 20)) && !v.imm[0];
        w[31] = v.imm[20]; w[30:21] = v.imm[10:1]; w[20] = v.imm[11];
        w[19:12] = v.imm[19:12]; w[11:7] = v.rd;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h0000_0013;
    return {~ok, w};
  endfunction

  // Output side of the scoreboard, plus hold-stability and word_cnt tracking.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
      if (hold_valid) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_instr", out_instr, hold_instr);
        chk("hold_addr", 32'(out_addr), 32'(hold_addr));
        chk("hold_err", 32'(out_err), 32'(hold_err));
      end
      hold_valid = out_valid && !out_ready && !clear;
      hold_instr = out_instr;
      hold_addr  = out_addr;
      hold_err   = out_err;
      if (out_valid && out_ready && !clear) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got instr %h with empty scoreboard", out_instr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_err", 32'(out_err), 32'(e.err));
          chk("out_addr", 32'(out_addr), 32'(e.addr));
        end
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
      end
    end
  end

  task automatic flush_model();
    sb.delete();
    exp_idx    = 0;
    exp_cnt    = 16'h0;
    hold_valid = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_funct3 = v.f3;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v, input logic [31:0] ei, input logic ee);
    int   n;
    exp_t e;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %b", in_ready);
    end else begin
      e.instr = ei;
      e.err   = ee;
      e.addr  = ADDR_W'(BASE_ADDR + 4 * exp_idx);
      sb.push_back(e);
      exp_idx = (exp_idx + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1.
  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    flush_model();
    @(negedge clk);
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    chk("clear_word_cnt", 32'(word_cnt), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [32:0] r;
    vecs[0]  = mk(3'd1, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    vecs[1]  = mk(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'h0000_0008, 32'h0020_8463, 1'b0);
    vecs[2]  = mk(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'h0000_0007, 32'h0000_0013, 1'b1);
    vecs[3]  = mk(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    vecs[4]  = mk(3'd1, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00, 32'h0000_0800, 32'h0000_0013, 1'b1);
    vecs[5]  = mk(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    vecs[6]  = mk(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
    vecs[7]  = mk(3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd3, 7'h00, 32'hFFFF_FFFC, 32'hFE31_2E23, 1'b0);
    vecs[8]  = mk(3'd6, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1);
    vecs[9]  = mk(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h1234_5001, 32'h0000_0013, 1'b1);
    vecs[10] = mk(3'd5, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0);
    vecs[11] = mk(3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd3, 7'h00, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1);

    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; done = 1'b0;
    drive(vecs[0]);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_addr", 32'(out_addr), BASE_ADDR);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // Two-cycle latency on the first word.
    send(vecs[0], vecs[0].ei, vecs[0].ee);
    @(negedge clk);
    chk("latency_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_c2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Table vectors streamed back to back; five or more words exercise the wrap.
    for (int i = 1; i < 12; i++) send(vecs[i], vecs[i].ei, vecs[i].ee);
    drain();

    // Backpressure: two words fill the pipe, the third waits.
    do_clear();
    out_ready = 1'b0;
    send(vecs[0], vecs[0].ei, vecs[0].ee);
    send(vecs[1], vecs[1].ei, vecs[1].ee);
    drive(vecs[5]);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vecs[5], vecs[5].ei, vecs[5].ee);
    drain();
    @(negedge clk);
    chk("bp_word_cnt", 32'(word_cnt), 32'd3);
    @(posedge clk);
    #1;

    // clear with two words in flight and a competing input.
    out_ready = 1'b0;
    send(vecs[0], vecs[0].ei, vecs[0].ee);
    send(vecs[1], vecs[1].ei, vecs[1].ee);
    drive(vecs[3]);
    in_valid = 1'b1;
    do_clear();
    out_ready = 1'b1;
    send(vecs[5], vecs[5].ei, vecs[5].ee);
    drain();

    // Random stream with random backpressure, checked against the reference encoder.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          v.fmt = 3'($urandom_range(0, 7));
          v.op  = 7'($urandom); v.rd = 5'($urandom); v.f3 = 3'($urandom);
          v.rs1 = 5'($urandom); v.rs2 = 5'($urandom); v.f7 = 7'($urandom);
          case ($urandom_range(0, 3))
            0: v.imm = $urandom;
            1: v.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: v.imm = {20'($urandom), 12'h0};
            default: v.imm = 32'($urandom_range(0, 3000000)) - 32'd1500000;
          endcase
          r = ref_enc(v);
          send(v, r[31:0], r[32]);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Asynchronous reset while words are held in the pipe.
    out_ready = 1'b0;
    send(vecs[6], vecs[6].ei, vecs[6].ee);
    send(vecs[7], vecs[7].ei, vecs[7].ee);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    chk("arst_out_addr", 32'(out_addr), BASE_ADDR);
    chk("arst_word_cnt", 32'(word_cnt), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    flush_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(vecs[5], vecs[5].ei, vecs[5].ee);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
